// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the two-client ALU arbiter: datapath
//               width and the ALUop encodings understood by the alu.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : DATA_WIDTH           default operand/result width
//               OP_AND .. OP_SLT     3-bit ALUop codes
// ============================================================================
package alu_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 32-bit ALU (AND, OR, ADD, SUB, SLT) producing
//               the result plus Overflow, CarryOut and Zero flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : a_i, b_i        in  DATA_WIDTH  operands
//               alu_op_i        in  3           operation code
//               result_o        out DATA_WIDTH  operation result
//               overflow_o      out 1           signed overflow (ADD/SUB only)
//               carry_out_o     out 1           carry out (ADD/SUB only)
//               zero_o          out 1           result is all zeros
// ============================================================================
module alu #(
    parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [2:0]            alu_op_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  overflow_o,
    output logic                  carry_out_o,
    output logic                  zero_o
);
    import alu_arbiter_pkg::*;

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum_add;
    logic [DATA_WIDTH:0] sum_sub;
    logic                ovf_add;
    logic                ovf_sub;
    logic                slt_bit;

    // Subtraction is A + ~B + 1, so CarryOut = 1 means "no borrow".
    assign sum_add = {1'b0, a_i} + {1'b0, b_i};
    assign sum_sub = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_WIDTH+1)'(1);

    assign ovf_add = (a_i[MSB] == b_i[MSB]) && (sum_add[MSB] != a_i[MSB]);
    assign ovf_sub = (a_i[MSB] != b_i[MSB]) && (sum_sub[MSB] != a_i[MSB]);

    // Signed less-than: sign of the difference, corrected for overflow.
    assign slt_bit = sum_sub[MSB] ^ ovf_sub;

    always_comb begin
        result_o    = '0;
        overflow_o  = 1'b0;
        carry_out_o = 1'b0;
        case (alu_op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_ADD: begin
                result_o    = sum_add[MSB:0];
                carry_out_o = sum_add[DATA_WIDTH];
                overflow_o  = ovf_add;
            end
            OP_SUB: begin
                result_o    = sum_sub[MSB:0];
                carry_out_o = sum_sub[DATA_WIDTH];
                overflow_o  = ovf_sub;
            end
            // SLT reports only the comparison; arithmetic flags stay clear.
            OP_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            // Unsupported codes yield zero, which raises Zero below.
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter and sequencer sharing one alu between two
//               requesters. Each accepted request is registered, executed for
//               one cycle, and its result/flags returned on a valid/ready
//               response channel to the issuing requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk                     in  1   rising-edge clock
//               rst                     in  1   async active-high reset
//               req_valid_i             in  2   per-requester request valid
//               req_ready_o             out 2   per-requester request accept
//               req_a0_i, req_b0_i      in  DW  requester 0 operands
//               req_a1_i, req_b1_i      in  DW  requester 1 operands
//               req_op0_i, req_op1_i    in  3   requester ALUop codes
//               resp_valid_o            out 2   response pending for owner
//               resp_ready_i            in  2   per-requester response accept
//               resp_result_o           out DW  shared response result
//               resp_flags_o            out 3   {Overflow, CarryOut, Zero}
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_a0_i,
    input  logic [DATA_WIDTH-1:0] req_b0_i,
    input  logic [DATA_WIDTH-1:0] req_a1_i,
    input  logic [DATA_WIDTH-1:0] req_b1_i,
    input  logic [2:0]            req_op0_i,
    input  logic [2:0]            req_op1_i,
    output logic [1:0]            resp_valid_o,
    input  logic [1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_result_o,
    output logic [2:0]            resp_flags_o
);
    import alu_arbiter_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic                  rr_q,     rr_d;
    logic                  owner_q,  owner_d;
    logic [DATA_WIDTH-1:0] a_q,      a_d;
    logic [DATA_WIDTH-1:0] b_q,      b_d;
    logic [2:0]            op_q,     op_d;
    logic [DATA_WIDTH-1:0] res_q,    res_d;
    logic [2:0]            flags_q,  flags_d;

    logic [1:0]            grant;
    logic                  grant_sel;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_overflow;
    logic                  alu_carry_out;
    logic                  alu_zero;

    // ------------------------------------------------------------------
    // Shared ALU: driven only from the operand registers.
    // ------------------------------------------------------------------
    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a_i         (a_q),
        .b_i         (b_q),
        .alu_op_i    (op_q),
        .result_o    (alu_result),
        .overflow_o  (alu_overflow),
        .carry_out_o (alu_carry_out),
        .zero_o      (alu_zero)
    );

    // ------------------------------------------------------------------
    // Round-robin grant: a lone requester always wins; on contention the
    // requester named by rr_q wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // grant is one-hot when non-zero, so bit 1 names the winner.
    assign grant_sel = grant[1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            res_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        flags_d      = flags_q;
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = grant;
                // A ready bit is only raised for a valid requester, so any
                // non-zero grant is a completed handshake.
                if (grant != 2'b00) begin
                    owner_d = grant_sel;
                    rr_d    = ~grant_sel;
                    a_d     = grant_sel ? req_a1_i  : req_a0_i;
                    b_d     = grant_sel ? req_b1_i  : req_b0_i;
                    op_d    = grant_sel ? req_op1_i : req_op0_i;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                res_d   = alu_result;
                flags_d = {alu_overflow, alu_carry_out, alu_zero};
                state_d = ST_RESP;
            end

            ST_RESP: begin
                resp_valid_o[owner_q] = 1'b1;
                // Only the owner's ready bit can retire the response.
                if (resp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_result_o = res_q;
    assign resp_flags_o  = flags_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter. Each scenario
//               task drives requests and compares outputs against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;
    logic [2:0]  resp_flags;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a0_i      (req_a0),
        .req_b0_i      (req_b0),
        .req_a1_i      (req_a1),
        .req_b1_i      (req_b1),
        .req_op0_i     (req_op0),
        .req_op1_i     (req_op1),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .resp_flags_o  (resp_flags)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = 3'b000; req_op1 = 3'b000;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        checks++;
        if (resp_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", resp_result); end
        checks++;
        if (resp_flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", resp_flags); end
        tick();
    endtask

    task automatic test_single_add();
        resp_ready = 2'b11;
        req_a0 = 32'h7FFF_FFFF; req_b0 = 32'h1; req_op0 = 3'b010;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL add_handshake: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL add_exec_no_resp: got %b want 00", resp_valid); end
        tick();
        checks++;
        if (resp_valid !== 2'b01) begin errors++; $display("FAIL add_resp_valid: got %b want 01", resp_valid); end
        checks++;
        if (resp_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h want 80000000", resp_result); end
        checks++;
        if (resp_flags !== 3'b100) begin errors++; $display("FAIL add_flags: got %b want 100", resp_flags); end
        tick();
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL add_resp_retired: got %b want 00", resp_valid); end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; tick(); rst = 1'b0;
        resp_ready = 2'b11;
        req_a0 = 32'd5;          req_b0 = 32'd5; req_op0 = 3'b110;
        req_a1 = 32'hFFFF_FFFF;  req_b1 = 32'd1; req_op1 = 3'b111;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL sim_first_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL sim_exec_ready: got %b want 00", req_ready); end
        tick();
        checks++;
        if (resp_valid !== 2'b01) begin errors++; $display("FAIL sim_sub_valid: got %b want 01", resp_valid); end
        checks++;
        if (resp_result !== 32'h0) begin errors++; $display("FAIL sim_sub_result: got %h want 0", resp_result); end
        checks++;
        if (resp_flags !== 3'b011) begin errors++; $display("FAIL sim_sub_flags: got %b want 011", resp_flags); end
        tick();
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL sim_second_grant: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b10) begin errors++; $display("FAIL sim_slt_valid: got %b want 10", resp_valid); end
        checks++;
        if (resp_result !== 32'h1) begin errors++; $display("FAIL sim_slt_result: got %h want 1", resp_result); end
        checks++;
        if (resp_flags !== 3'b000) begin errors++; $display("FAIL sim_slt_flags: got %b want 000", resp_flags); end
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] want;
        bit         seen;
        resp_ready = 2'b11;
        req_a0 = 32'd10; req_b0 = 32'd1; req_op0 = 3'b010;
        req_a1 = 32'd20; req_b1 = 32'd2; req_op1 = 3'b010;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                checks++;
                if (req_ready === 2'b11) begin errors++; $display("FAIL fair_both_ready: got %b want not 11", req_ready); end
                if (req_ready !== 2'b00) begin
                    seen = 1'b1;
                    checks++;
                    if (req_ready !== want) begin errors++; $display("FAIL fair_order_%0d: got %b want %b", k, req_ready, want); end
                end
                tick();
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL fair_timeout_%0d: got no grant want %b", k, want);
            end
        end
        // Let the sixth operation drain before the next scenario.
        req_valid = 2'b00;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        resp_ready = 2'b01;
        req_a1 = 32'd20; req_b1 = 32'd22; req_op1 = 3'b010;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1: got %b want 10", req_ready); end
        tick();
        req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 3'b001;
        req_valid = 2'b01;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (resp_valid !== 2'b10) begin errors++; $display("FAIL bp_stall_valid_%0d: got %b want 10", c, resp_valid); end
            checks++;
            if (resp_result !== 32'd42) begin errors++; $display("FAIL bp_stall_result_%0d: got %h want 2a", c, resp_result); end
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready_%0d: got %b want 00", c, req_ready); end
            tick();
        end
        resp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_release_ready: got %b want 00", req_ready); end
        tick();
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0_after: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b01 || resp_result !== 32'd7) begin
            errors++; $display("FAIL bp_or_resp: got valid=%b res=%h want valid=01 res=7", resp_valid, resp_result);
        end
        tick();
    endtask

    task automatic test_reset_exec();
        resp_ready = 2'b11;
        req_a0 = 32'h0000_00F0; req_b0 = 32'h0000_000F; req_op0 = 3'b001;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL rstx_req_ready: got %b want 00", req_ready); end
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL rstx_resp_valid: got %b want 00", resp_valid); end
        checks++;
        if (resp_result !== 32'h0) begin errors++; $display("FAIL rstx_result: got %h want 0", resp_result); end
        checks++;
        if (resp_flags !== 3'b000) begin errors++; $display("FAIL rstx_flags: got %b want 000", resp_flags); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (resp_valid !== 2'b00) begin errors++; $display("FAIL rstx_no_resp_%0d: got %b want 00", c, resp_valid); end
        end
        req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 3'b010;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rstx_rr_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_result !== 32'h0000_00FF) begin errors++; $display("FAIL rstx_or_result: got %h want ff", resp_result); end
        tick();
    endtask

    task automatic test_unsupported();
        resp_ready = 2'b11;
        req_a1 = 32'h123; req_b1 = 32'h456; req_op1 = 3'b100;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL unsup_grant: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b10) begin errors++; $display("FAIL unsup_valid: got %b want 10", resp_valid); end
        checks++;
        if (resp_result !== 32'h0) begin errors++; $display("FAIL unsup_result: got %h want 0", resp_result); end
        checks++;
        if (resp_flags !== 3'b001) begin errors++; $display("FAIL unsup_flags: got %b want 001", resp_flags); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_reset_exec();
        test_unsupported();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire
